sram_wishbone_interface: RTL
============================

Name: sram_wishbone_interface

Overview:
- Front-end stage that feeds the dual-port SRAM wrapper (primary RW port plus secondary R port).
- Converts a Wishbone classic slave (32-bit, byte-addressed) into primary-port strobes.
- Converts a core fetch request/response stream with back-pressure into secondary-port reads.
- Owns the SRAM's one-cycle read latency, so neither upstream master sees SRAM timing.

Parameters:
- BYTE_COUNT, 4, bytes per word; WORD_SIZE = 8*BYTE_COUNT; only 4 supported.
- ADDRESS_SIZE, 9, word-address width driven to the SRAM wrapper.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wbCyc  in  1  Wishbone cycle
- wbStb  in  1  Wishbone strobe
- wbWe  in  1  Wishbone write enable
- wbSel  in  BYTE_COUNT  byte selects
- wbAddress  in  ADDRESS_SIZE+2  byte address; word address = wbAddress[ADDRESS_SIZE+1:2]
- wbDataWrite  in  WORD_SIZE  write data
- wbAck  out  1  acknowledge
- wbDataRead  out  WORD_SIZE  read data
- fetchRequest  in  1  fetch read request
- fetchAddress  in  ADDRESS_SIZE  fetch word address
- fetchReady  out  1  request accepted this cycle when fetchRequest is high
- fetchDataValid  out  1  fetchData valid
- fetchDataReady  in  1  consumer takes fetchData
- fetchData  out  WORD_SIZE  fetched word
- primarySelect, primaryWriteEnable  out  1 each  to SRAM
- primaryWriteMask  out  BYTE_COUNT  to SRAM
- primaryAddress  out  ADDRESS_SIZE  to SRAM
- primaryDataWrite  out  WORD_SIZE  to SRAM
- primaryDataRead  in  WORD_SIZE  from SRAM
- secondarySelect  out  1  to SRAM
- secondaryAddress  out  ADDRESS_SIZE  to SRAM
- secondaryDataRead  in  WORD_SIZE  from SRAM

Behaviour:
- SRAM contract: a read issued with select high at edge N presents valid dout during cycle N+1 and holds it until the next read on that port.

Reset:
- State is IDLE.
- wbAck=0, wbDataRead=0, fetchDataValid=0, holdValid=0, inflight=0.
- All select and write-enable outputs are 0.

Wishbone FSM, states IDLE, READ_WAIT, ACK:
- IDLE with wbCyc&wbStb: combinationally drive primarySelect=1, primaryAddress=word address, primaryWriteEnable=wbWe, primaryWriteMask=wbSel, primaryDataWrite=wbDataWrite.
  - Write: next state is ACK.
  - Read: next state is READ_WAIT.
- READ_WAIT: primarySelect=0. Register primaryDataRead into wbDataRead. Next state is ACK.
- ACK: wbAck=1 for exactly one cycle. Next state is IDLE.
- Latency: write ack on cycle 1 after the strobe cycle; read ack on cycle 2. At most one transaction is outstanding.
- Outside IDLE, the primary-port selects are 0 regardless of wbStb, so a held strobe is never double-issued.
- wbCyc low in READ_WAIT or ACK: return to IDLE next cycle and suppress wbAck. A write already issued is not undone.
- wbDataRead holds its value until the next read capture.

Fetch path:
- Issue condition: fetchReady = !holdValid && (!inflight || fetchDataReady) && !conflict.
- conflict = primary write issuing this cycle and fetchAddress equals the primary word address. This makes read-during-write to the same word impossible.
- On fetchRequest&fetchReady: secondarySelect=1, secondaryAddress=fetchAddress; set inflight next cycle, otherwise clear it.
- fetchDataValid = inflight | holdValid.
- fetchData = holdValid ? holdData : secondaryDataRead.
- inflight & !fetchDataReady & !holdValid: capture secondaryDataRead into holdData and set holdValid.
- holdValid & fetchDataReady: clear holdValid.
- Throughput is one word per cycle while fetchDataReady stays high. Words are delivered in order, with no loss or duplication.
- Wishbone and fetch paths are independent apart from the conflict stall; a simultaneous Wishbone read and fetch to any address both proceed.
- Reset mid-read discards in-flight data with no ack and no valid.

Decomposition:
- Package sram_interface_pkg holds:
  - the WB state encoding (IDLE=0, READ_WAIT=1, ACK=2);
  - the supported BYTE_COUNT constant;
  - the SRAM read-latency constant (1).
- One sub-module, sram_fetch_buffer, contains the inflight flag, hold register and ready/valid logic. The top level holds the WB FSM and the conflict compare.

Test Plan:
- Write/read-back: WB write 0xDEADBEEF, wbSel=4'hF, wbAddress=0x010; then WB read at 0x010. Required: write ack 1 cycle after strobe; read ack 2 cycles after strobe with wbDataRead=0xDEADBEEF; primaryAddress=4 on both.
- Byte mask: word 4 holds 0xDEADBEEF; write 0x00000011 with wbSel=4'b0001. Required: read returns 0xDEADBE11; primaryWriteMask=4'b0001 on the issue cycle.
- Fetch streaming: words 0..3 hold 0xA0..0xA3; fetchRequest held for addresses 0..3 with fetchDataReady=1. Required: fetchDataValid on 4 consecutive cycles, each 1 cycle after acceptance, carrying 0xA0..0xA3.
- Back-pressure: in the streaming scenario, drop fetchDataReady for 3 cycles after the first word. Required: fetchReady=0 during the stall; fetchData holds 0xA1 stable; resuming gives 0xA1, 0xA2, 0xA3 with none lost or duplicated.
- Conflict stall: WB write of 0x55 to word 7 and fetchRequest for word 7 in the same cycle. Required: fetchReady=0 that cycle; the next-cycle fetch returns 0x55.
- Abort and reset: drop wbCyc in READ_WAIT; assert rst while fetch data is held. Required: no wbAck, FSM back in IDLE; after reset all outputs are 0 and fetchDataValid=0.

Source files
------------

// File: rtl/sram_interface_pkg.sv
// Shared types and constants for the SRAM front-end stage.
// Wishbone FSM encoding plus SRAM timing constants.
package sram_interface_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    ACK       = 2'd2
  } wb_state_t;

  localparam int SUPPORTED_BYTE_COUNT = 4;
  localparam int READ_LATENCY = 1;

endpackage

// File: rtl/sram_fetch_buffer.sv
// Fetch path for the SRAM secondary read port.
// Hides the one-cycle read latency behind a valid/ready stream.
import sram_interface_pkg::*;

module sram_fetch_buffer #(
  parameter int ADDRESS_SIZE = 9,
  parameter int WORD_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetchRequest,
  input  logic [ADDRESS_SIZE-1:0] fetchAddress,
  input  logic                    conflict,
  input  logic                    fetchDataReady,
  input  logic [WORD_SIZE-1:0]    secondaryDataRead,
  output logic                    fetchReady,
  output logic                    fetchDataValid,
  output logic [WORD_SIZE-1:0]    fetchData,
  output logic                    secondarySelect,
  output logic [ADDRESS_SIZE-1:0] secondaryAddress
);

  logic                 inflight;
  logic                 holdValid;
  logic [WORD_SIZE-1:0] holdData;
  logic                 issue;

  assign fetchReady = !rst && !holdValid &&
                      (!inflight || fetchDataReady) &&
                      !conflict;
  assign issue = fetchRequest && fetchReady;

  assign secondarySelect  = issue;
  assign secondaryAddress = issue ? fetchAddress : '0;

  assign fetchDataValid = inflight | holdValid;
  // The SRAM only holds dout until its next read, so a
  // stalled word is parked in holdData before that happens.
  assign fetchData = holdValid ? holdData :
                     inflight  ? secondaryDataRead : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight  <= 1'b0;
      holdValid <= 1'b0;
      holdData  <= '0;
    end else begin
      inflight <= issue;
      if (inflight && !fetchDataReady && !holdValid) begin
        holdData  <= secondaryDataRead;
        holdValid <= 1'b1;
      end else if (holdValid && fetchDataReady) begin
        holdValid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_wishbone_interface.sv
// Front-end stage: Wishbone slave on the SRAM primary port,
// core fetch stream on the SRAM secondary read port.
import sram_interface_pkg::*;

module sram_wishbone_interface #(
  parameter int BYTE_COUNT = 4,
  parameter int ADDRESS_SIZE = 9,
  localparam int WORD_SIZE = 8 * BYTE_COUNT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wbCyc,
  input  logic                    wbStb,
  input  logic                    wbWe,
  input  logic [BYTE_COUNT-1:0]   wbSel,
  input  logic [ADDRESS_SIZE+1:0] wbAddress,
  input  logic [WORD_SIZE-1:0]    wbDataWrite,
  output logic                    wbAck,
  output logic [WORD_SIZE-1:0]    wbDataRead,
  input  logic                    fetchRequest,
  input  logic [ADDRESS_SIZE-1:0] fetchAddress,
  output logic                    fetchReady,
  output logic                    fetchDataValid,
  input  logic                    fetchDataReady,
  output logic [WORD_SIZE-1:0]    fetchData,
  output logic                    primarySelect,
  output logic                    primaryWriteEnable,
  output logic [BYTE_COUNT-1:0]   primaryWriteMask,
  output logic [ADDRESS_SIZE-1:0] primaryAddress,
  output logic [WORD_SIZE-1:0]    primaryDataWrite,
  input  logic [WORD_SIZE-1:0]    primaryDataRead,
  output logic                    secondarySelect,
  output logic [ADDRESS_SIZE-1:0] secondaryAddress,
  input  logic [WORD_SIZE-1:0]    secondaryDataRead
);

  wb_state_t               state;
  logic [ADDRESS_SIZE-1:0] wb_word;
  logic                    wb_issue;
  logic                    conflict;

  assign wb_word  = wbAddress[ADDRESS_SIZE+1:2];
  // Only IDLE issues, so a strobe held through the ack
  // never reaches the SRAM twice.
  assign wb_issue = !rst && (state == IDLE) && wbCyc && wbStb;

  assign primarySelect      = wb_issue;
  assign primaryWriteEnable = wb_issue && wbWe;
  assign primaryWriteMask   = wb_issue ? wbSel : '0;
  assign primaryAddress     = wb_issue ? wb_word : '0;
  assign primaryDataWrite   = wb_issue ? wbDataWrite : '0;

  assign wbAck = (state == ACK) && wbCyc;

  assign conflict = primaryWriteEnable && (fetchAddress == wb_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wbDataRead <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wbCyc && wbStb)
            state <= wbWe ? ACK : READ_WAIT;
        end
        READ_WAIT: begin
          if (!wbCyc) begin
            state <= IDLE;
          end else begin
            wbDataRead <= primaryDataRead;
            state      <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sram_fetch_buffer #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .WORD_SIZE    (WORD_SIZE)
  ) u_fetch (
    .clk               (clk),
    .rst               (rst),
    .fetchRequest      (fetchRequest),
    .fetchAddress      (fetchAddress),
    .conflict          (conflict),
    .fetchDataReady    (fetchDataReady),
    .secondaryDataRead (secondaryDataRead),
    .fetchReady        (fetchReady),
    .fetchDataValid    (fetchDataValid),
    .fetchData         (fetchData),
    .secondarySelect   (secondarySelect),
    .secondaryAddress  (secondaryAddress)
  );

endmodule
